stage_instruction_decode: RTL and testbench
===========================================

// Module: stage_instruction_decode
// PURPOSE
//  RV32I decode stage; receiving end of the instruction-fetch output interface (PC, NextPC, instruction word, misaligned flag).
//  Holds the IF/ID pipeline register, decodes fields and immediates, and owns the 32x32 integer register file.
//  Presents a registered, decoded instruction with operands to execute; the write-back stage writes the register file directly.
// PARAMETERS
//  XLEN   32  data/address width; only 32 is supported
//  NREGS  32  architectural registers; x0 is hard-wired to zero
// PORTS
//  i_Clock                          in   1   rising-edge clock
//  i_Reset                          in   1   asynchronous, ACTIVE-LOW reset
//  i_Valid                          in   1   IF presents an instruction this cycle
//  i_PC / i_NextPC                  in   32  address of the instruction / of its sequential successor
//  i_InstructionWord                in   32  raw instruction
//  i_InstructionAddressMisaligned   in   1   IF fault flag, passed through
//  o_Ready                          out  1   ID accepts from IF this cycle
//  i_Stall                          in   1   downstream cannot accept; hold outputs
//  i_Flush                          in   1   squash the held instruction (branch/trap)
//  i_WB_WriteEnable                 in   1   register-file write strobe
//  i_WB_Rd                          in   5   write destination
//  i_WB_Data                        in   32  write data
//  o_Valid                          out  1   decoded instruction valid
//  o_PC / o_NextPC                  out  32  registered copies
//  o_Opcode                         out  7   instr[6:0]
//  o_Funct3 / o_Funct7              out  3/7 instr[14:12] / instr[31:25]
//  o_Rs1 / o_Rs2 / o_Rd             out  5   register indices
//  o_Rs1Data / o_Rs2Data            out  32  operand values
//  o_Immediate                      out  32  sign-extended immediate
//  o_IllegalInstruction             out  1   unsupported encoding
//  o_InstructionAddressMisaligned   out  1   registered pass-through
// BEHAVIOUR
//  - Reset (i_Reset=0, async): every output register is 0, including o_Valid. Register-file contents are NOT reset.
//  - o_Ready = !i_Stall (combinational). Capture occurs on a clock edge with i_Valid && o_Ready && !i_Flush.
//  - Latency: 1 cycle from capture to o_Valid=1 with all decoded outputs.
//  - Edge priority: Flush > Stall > capture > bubble.
//    - Flush: o_Valid<=0 (other outputs don't-care). Applies even while stalled.
//    - Stall: all outputs hold.
//    - No stall and no capture: o_Valid<=0.
//  - Immediate by o_Opcode:
//    - I-type (0x03, 0x13, 0x67, 0x73): sext(instr[31:20]).
//    - S (0x23): sext({instr[31:25], instr[11:7]}).
//    - B (0x63): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
//    - U (0x37, 0x17): {instr[31:12], 12'b0}.
//    - J (0x6F): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
//    - R (0x33), FENCE (0x0F) and others: 0.
//  - Illegal: instr[1:0]!=2'b11, or opcode not in {03, 0F, 13, 17, 23, 33, 37, 63, 67, 6F, 73}. The instruction is still captured with o_Valid=1 and o_IllegalInstruction=1.
//  - Register file: 2 combinational read ports sampled at capture; 1 synchronous write port.
//    - A write to x0 is ignored; a read of x0 returns 0.
//    - Same-edge write and capture: the captured value is the pre-write contents (unless the bypass below is enabled).
// CONFIGURATION
//  ID_WB_BYPASS_EN defined:
//    - At capture, if i_WB_WriteEnable && i_WB_Rd!=0 && i_WB_Rd==rs, the operand captures i_WB_Data.
//    - While o_Valid=1 and stalled, a matching write (rd!=0) also updates the held o_Rs1Data/o_Rs2Data.
//  ID_WB_BYPASS_EN undefined:
//    - No forwarding; operands reflect pre-write contents.
//    - External hazard logic must stall.
// TESTING
//  1 Hold i_Reset=0, then release -> o_Valid=0 and all outputs 0 until the first capture.
//  2 Capture 0x00500093 (addi x1,x0,5), PC=0x100 -> next cycle o_Valid=1, o_Opcode=0x13, o_Rd=1, o_Rs1=0, o_Immediate=5, o_Rs1Data=0, o_PC=0x100.
//  3 Write x2=0xDEADBEEF, then capture 0x002101B3 (add x3,x2,x2) -> o_Rs1Data=o_Rs2Data=0xDEADBEEF, o_Funct7=0, o_Immediate=0.
//  4 Capture 0xFE000EE3 (beq x0,x0,-4) -> o_Immediate=0xFFFFFFFC. Then stall 3 cycles -> outputs unchanged; o_Ready=0.
//  5 Assert i_Flush with i_Stall=1 -> o_Valid=0 next edge. Capture 0x00000000 -> o_IllegalInstruction=1, o_Valid=1.
//  6 Same edge: write x5=0x1234 and capture add x6,x5,x0 -> bypass defined: o_Rs1Data=0x1234; undefined: old x5. Write x0=7 -> x0 still reads 0.

Source files
------------

// File: rtl/stage_instruction_decode.sv
// RV32I decode stage: IF/ID pipeline register, field/immediate decode and 32x32 register file.
// Optional write-back forwarding into captured/held operands is enabled by defining ID_WB_BYPASS_EN.
module stage_instruction_decode #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_Valid,
    input  logic [XLEN-1:0] i_PC,
    input  logic [XLEN-1:0] i_NextPC,
    input  logic [XLEN-1:0] i_InstructionWord,
    input  logic            i_InstructionAddressMisaligned,
    output logic            o_Ready,
    input  logic            i_Stall,
    input  logic            i_Flush,
    input  logic            i_WB_WriteEnable,
    input  logic [4:0]      i_WB_Rd,
    input  logic [XLEN-1:0] i_WB_Data,
    output logic            o_Valid,
    output logic [XLEN-1:0] o_PC,
    output logic [XLEN-1:0] o_NextPC,
    output logic [6:0]      o_Opcode,
    output logic [2:0]      o_Funct3,
    output logic [6:0]      o_Funct7,
    output logic [4:0]      o_Rs1,
    output logic [4:0]      o_Rs2,
    output logic [4:0]      o_Rd,
    output logic [XLEN-1:0] o_Rs1Data,
    output logic [XLEN-1:0] o_Rs2Data,
    output logic [XLEN-1:0] o_Immediate,
    output logic            o_IllegalInstruction,
    output logic            o_InstructionAddressMisaligned
);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic            illegal;

    assign instr   = i_InstructionWord;
    assign opcode  = instr[6:0];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign o_Ready = !i_Stall;

    // Register file is deliberately not reset; x0 is never written.
    always_ff @(posedge i_Clock) begin
        if (i_WB_WriteEnable && i_WB_Rd != '0)
            regs[i_WB_Rd] <= i_WB_Data;
    end

    always_comb begin
        rs1_val = (rs1 == '0) ? '0 : regs[rs1];
        rs2_val = (rs2 == '0) ? '0 : regs[rs2];
`ifdef ID_WB_BYPASS_EN
        if (i_WB_WriteEnable && i_WB_Rd != '0 && i_WB_Rd == rs1)
            rs1_val = i_WB_Data;
        if (i_WB_WriteEnable && i_WB_Rd != '0 && i_WB_Rd == rs2)
            rs2_val = i_WB_Data;
`endif
    end

    always_comb begin
        imm = '0;
        case (opcode)
            7'h03, 7'h13, 7'h67, 7'h73:
                imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            7'h23:
                imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            7'h63:
                imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            7'h37, 7'h17:
                imm = {instr[31:12], 12'b0};
            7'h6F:
                imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    always_comb begin
        illegal = 1'b1;
        case (opcode)
            7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73:
                illegal = 1'b0;
            default:
                illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11)
            illegal = 1'b1;
    end

    // Priority: flush, stall (hold), capture, bubble.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            o_Valid                        <= 1'b0;
            o_PC                           <= '0;
            o_NextPC                       <= '0;
            o_Opcode                       <= '0;
            o_Funct3                       <= '0;
            o_Funct7                       <= '0;
            o_Rs1                          <= '0;
            o_Rs2                          <= '0;
            o_Rd                           <= '0;
            o_Rs1Data                      <= '0;
            o_Rs2Data                      <= '0;
            o_Immediate                    <= '0;
            o_IllegalInstruction           <= 1'b0;
            o_InstructionAddressMisaligned <= 1'b0;
        end else if (i_Flush) begin
            o_Valid <= 1'b0;
        end else if (i_Stall) begin
`ifdef ID_WB_BYPASS_EN
            if (o_Valid && i_WB_WriteEnable && i_WB_Rd != '0) begin
                if (i_WB_Rd == o_Rs1)
                    o_Rs1Data <= i_WB_Data;
                if (i_WB_Rd == o_Rs2)
                    o_Rs2Data <= i_WB_Data;
            end
`endif
        end else if (i_Valid) begin
            o_Valid                        <= 1'b1;
            o_PC                           <= i_PC;
            o_NextPC                       <= i_NextPC;
            o_Opcode                       <= opcode;
            o_Funct3                       <= instr[14:12];
            o_Funct7                       <= instr[31:25];
            o_Rs1                          <= rs1;
            o_Rs2                          <= rs2;
            o_Rd                           <= instr[11:7];
            o_Rs1Data                      <= rs1_val;
            o_Rs2Data                      <= rs2_val;
            o_Immediate                    <= imm;
            o_IllegalInstruction           <= illegal;
            o_InstructionAddressMisaligned <= i_InstructionAddressMisaligned;
        end else begin
            o_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_instruction_decode.sv
// Scoreboard bench for stage_instruction_decode: driver pushes model expectations, monitor pops and compares.
// Build with or without ID_WB_BYPASS_EN; the reference model follows the same macro.
module tb_stage_instruction_decode;

    logic        i_Clock = 1'b0;
    logic        i_Reset;
    logic        i_Valid;
    logic [31:0] i_PC, i_NextPC, i_InstructionWord;
    logic        i_InstructionAddressMisaligned;
    logic        o_Ready;
    logic        i_Stall, i_Flush;
    logic        i_WB_WriteEnable;
    logic [4:0]  i_WB_Rd;
    logic [31:0] i_WB_Data;
    logic        o_Valid;
    logic [31:0] o_PC, o_NextPC;
    logic [6:0]  o_Opcode;
    logic [2:0]  o_Funct3;
    logic [6:0]  o_Funct7;
    logic [4:0]  o_Rs1, o_Rs2, o_Rd;
    logic [31:0] o_Rs1Data, o_Rs2Data, o_Immediate;
    logic        o_IllegalInstruction, o_InstructionAddressMisaligned;

    stage_instruction_decode #(.XLEN(32), .NREGS(32)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Valid(i_Valid),
        .i_PC(i_PC), .i_NextPC(i_NextPC), .i_InstructionWord(i_InstructionWord),
        .i_InstructionAddressMisaligned(i_InstructionAddressMisaligned),
        .o_Ready(o_Ready), .i_Stall(i_Stall), .i_Flush(i_Flush),
        .i_WB_WriteEnable(i_WB_WriteEnable), .i_WB_Rd(i_WB_Rd), .i_WB_Data(i_WB_Data),
        .o_Valid(o_Valid), .o_PC(o_PC), .o_NextPC(o_NextPC), .o_Opcode(o_Opcode),
        .o_Funct3(o_Funct3), .o_Funct7(o_Funct7), .o_Rs1(o_Rs1), .o_Rs2(o_Rs2), .o_Rd(o_Rd),
        .o_Rs1Data(o_Rs1Data), .o_Rs2Data(o_Rs2Data), .o_Immediate(o_Immediate),
        .o_IllegalInstruction(o_IllegalInstruction),
        .o_InstructionAddressMisaligned(o_InstructionAddressMisaligned)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct {
        logic        valid;
        logic [31:0] pc, npc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        ill, mis;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_rf [32];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [6:0]  legal_ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                    7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] read_model(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (i_WB_WriteEnable && i_WB_Rd == idx) return i_WB_Data;
`endif
        return model_rf[idx];
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input logic mis);
        exp_t        e;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        e.valid = 1'b1;
        e.pc  = pc;
        e.npc = pc + 32'd4;
        e.op  = w[6:0];
        e.f3  = w[14:12];
        e.f7  = w[31:25];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        e.d1  = read_model(w[19:15]);
        e.d2  = read_model(w[24:20]);
        e.mis = mis;
        e.ill = !(w[1:0] == 2'b11 && (w[6:0] inside {legal_ops}));
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin i12 = w[31:20]; e.imm = 32'($signed(i12)); end
            7'h23: begin i12 = {w[31:25], w[11:7]}; e.imm = 32'($signed(i12)); end
            7'h63: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; e.imm = 32'($signed(b13)); end
            7'h37, 7'h17: e.imm = w & 32'hFFFF_F000;
            7'h6F: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; e.imm = 32'($signed(j21)); end
            default: e.imm = 32'h0;
        endcase
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc, input logic mis,
                         input logic st, input logic fl, input logic we, input logic [4:0] rd,
                         input logic [31:0] d);
        i_Valid = v; i_InstructionWord = w; i_PC = pc; i_NextPC = pc + 32'd4;
        i_InstructionAddressMisaligned = mis; i_Stall = st; i_Flush = fl;
        i_WB_WriteEnable = we; i_WB_Rd = rd; i_WB_Data = d;
        #1 chk("ready", {31'b0, o_Ready}, {31'b0, !st});
        if (v && !st && !fl) q.push_back(model(w, pc, mis));
        @(posedge i_Clock);
        if (we && rd != 0) model_rf[rd] = d;
        @(negedge i_Clock);
    endtask

    // Monitor: tracks what the outputs must show after each edge and compares on the falling edge.
    initial begin : monitor
        exp_t cur;
        bit   known, pristine;
        logic rst, st, fl, v, we;
        logic [4:0]  wrd;
        logic [31:0] wd;
        cur = '{default: '0};
        known = 1; pristine = 1;
        forever begin
            @(posedge i_Clock);
            rst = i_Reset; st = i_Stall; fl = i_Flush; v = i_Valid;
            we = i_WB_WriteEnable; wrd = i_WB_Rd; wd = i_WB_Data;
            if (rst !== 1'b1) begin
                cur = '{default: '0}; known = 1; pristine = 1;
            end else if (fl) begin
                cur.valid = 0; known = 0;
            end else if (st) begin
`ifdef ID_WB_BYPASS_EN
                if (cur.valid && we && wrd != 0) begin
                    if (wrd == cur.rs1) cur.d1 = wd;
                    if (wrd == cur.rs2) cur.d2 = wd;
                end
`endif
            end else if (v) begin
                if (q.size() == 0) begin
                    chk("queue_nonempty", 32'd0, 32'd1);
                    cur.valid = 1; known = 0;
                end else begin
                    cur = q.pop_front(); known = 1; pristine = 0;
                end
            end else begin
                cur.valid = 0;
                if (!pristine) known = 0;
            end
            @(negedge i_Clock);
            chk("valid", {31'b0, o_Valid}, {31'b0, cur.valid});
            if (known) begin
                chk("pc", o_PC, cur.pc);
                chk("npc", o_NextPC, cur.npc);
                chk("opcode", {25'b0, o_Opcode}, {25'b0, cur.op});
                chk("funct3", {29'b0, o_Funct3}, {29'b0, cur.f3});
                chk("funct7", {25'b0, o_Funct7}, {25'b0, cur.f7});
                chk("rs1", {27'b0, o_Rs1}, {27'b0, cur.rs1});
                chk("rs2", {27'b0, o_Rs2}, {27'b0, cur.rs2});
                chk("rd", {27'b0, o_Rd}, {27'b0, cur.rd});
                chk("rs1data", o_Rs1Data, cur.d1);
                chk("rs2data", o_Rs2Data, cur.d2);
                chk("imm", o_Immediate, cur.imm);
                chk("illegal", {31'b0, o_IllegalInstruction}, {31'b0, cur.ill});
                chk("misaligned", {31'b0, o_InstructionAddressMisaligned}, {31'b0, cur.mis});
            end
        end
    end

    initial begin : stimulus
        logic [31:0] w;
        i_Reset = 1'b0;
        i_Valid = 0; i_InstructionWord = '0; i_PC = '0; i_NextPC = '0;
        i_InstructionAddressMisaligned = 0; i_Stall = 0; i_Flush = 0;
        i_WB_WriteEnable = 0; i_WB_Rd = '0; i_WB_Data = '0;
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b1;
        // Idle with the register file being initialised: outputs stay at reset values.
        for (int r = 1; r < 32; r++) drive(0, $urandom, $urandom, 0, 0, 0, 1, 5'(r), $urandom);
        drive(1, 32'h0050_0093, 32'h100, 0, 0, 0, 0, 0, 0);           // addi x1,x0,5
        drive(0, 0, 0, 0, 0, 0, 1, 5'd2, 32'hDEAD_BEEF);
        drive(1, 32'h0021_01B3, 32'h104, 0, 0, 0, 0, 0, 0);           // add x3,x2,x2
        drive(1, 32'hFE00_0EE3, 32'h108, 1, 0, 0, 0, 0, 0);           // beq x0,x0,-4
        for (int k = 0; k < 3; k++) drive(1, $urandom, $urandom, 0, 1, 0, 0, 0, 0);
        drive(1, $urandom, $urandom, 0, 1, 1, 0, 0, 0);                // flush while stalled
        drive(1, 32'h0000_0000, 32'h10C, 0, 0, 0, 0, 0, 0);           // illegal
        drive(1, 32'h0002_8333, 32'h110, 0, 0, 0, 1, 5'd5, 32'h1234); // add x6,x5,x0 + write x5
        drive(1, 32'h0052_8433, 32'h114, 0, 0, 0, 0, 0, 0);           // add x8,x5,x5
        drive(0, 0, 0, 0, 1, 0, 1, 5'd5, 32'h5555);                    // write x5 while held
        drive(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h7);                       // write x0 ignored
        drive(1, 32'h0000_03B3, 32'h118, 0, 0, 0, 0, 0, 0);           // add x7,x0,x0
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = legal_ops[$urandom_range(0, 10)];
            drive($urandom_range(0, 9) < 7, w, $urandom, 1'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  1'($urandom), 5'($urandom), $urandom);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
